// File: rtl/parity_frame_checker.sv
// parity_frame_checker: accumulates per-frame XOR and one-count over framed words and reports the parity/framing verdict via valid/ready.
module parity_frame_checker #(
  parameter int WIDTH = 8,
  parameter int MAX_WORDS = 16,
  parameter int CNT_W = $clog2(MAX_WORDS + 1),
  parameter int ONES_W = $clog2(WIDTH * MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic              in_par,
  input  logic              odd_mode,
  output logic              running_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_ok,
  output logic              out_err_par,
  output logic              out_err_frame,
  output logic [CNT_W-1:0]  out_words,
  output logic [ONES_W-1:0] out_ones,
  output logic [7:0]        drop_cnt
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state;
  logic par, mode, ferr, errp, errf;
  logic [CNT_W-1:0] words, nxt_words;
  logic [ONES_W-1:0] ones, nxt_ones, pop;
  logic accept, frame_word, nxt_par, nxt_ferr, done_eof, done_ovf;
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + ONES_W'(in_data[i]);
  end
  assign in_ready    = state != HOLD;
  assign accept      = in_valid && in_ready;
  assign frame_word  = accept && (in_sof || state == ACCUM);
  // An sof word always restarts the accumulators, whether from IDLE or mid-frame.
  assign nxt_par     = (in_sof ? 1'b0 : par) ^ (^in_data);
  assign nxt_ones    = (in_sof ? '0 : ones) + pop;
  assign nxt_words   = (in_sof ? '0 : words) + CNT_W'(1);
  assign nxt_ferr    = in_sof ? state == ACCUM : ferr;
  assign done_eof    = frame_word && in_eof;
  assign done_ovf    = frame_word && !in_eof && nxt_words == CNT_W'(MAX_WORDS);
  assign running_par = par;
  assign out_valid     = state == HOLD;
  assign out_err_par   = out_valid && errp;
  assign out_err_frame = out_valid && errf;
  assign out_ok        = out_valid && !errp && !errf;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      par       <= 1'b0;
      mode      <= 1'b0;
      ferr      <= 1'b0;
      errp      <= 1'b0;
      errf      <= 1'b0;
      words     <= '0;
      ones      <= '0;
      out_words <= '0;
      out_ones  <= '0;
      drop_cnt  <= '0;
    end else begin
      if (frame_word) begin
        par   <= nxt_par;
        ones  <= nxt_ones;
        words <= nxt_words;
        mode  <= in_sof ? odd_mode : mode;
        ferr  <= nxt_ferr;
        state <= (done_eof || done_ovf) ? HOLD : ACCUM;
      end
      if (done_eof || done_ovf) begin
        out_words <= nxt_words;
        out_ones  <= nxt_ones;
        errf      <= nxt_ferr || done_ovf;
        errp      <= done_eof && ((nxt_par ^ in_par) != (in_sof ? odd_mode : mode));
      end
      if (accept && !frame_word && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      if (state == HOLD && out_ready) begin
        state <= IDLE;
        par   <= 1'b0;
        ones  <= '0;
        words <= '0;
      end
    end
  end
endmodule
